// File: rtl/wca_reg_byte_fifo_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wca_reg_byte_fifo_port_pkg
// Description : Shared definitions for the register-bus byte FIFO port:
//               rbusCtrl bit layout, status-register bit positions, the
//               read-FSM state encoding and a status-byte packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wca_reg_byte_fifo_port_pkg;

    // rbusCtrl = {addr[7:0], rdActive, wrStart, endStrobe, clkbus}
    localparam int C_CTRL_ADDR_MSB = 11;
    localparam int C_CTRL_ADDR_LSB = 4;
    localparam int C_CTRL_RD       = 3;
    localparam int C_CTRL_WR       = 2;
    localparam int C_CTRL_STB      = 1;
    localparam int C_CTRL_CLK      = 0;

    // Status byte layout; bits [5:4] read as zero
    localparam int C_STAT_TX_OVF   = 7;
    localparam int C_STAT_RX_UNF   = 6;
    localparam int C_STAT_TX_FULL  = 3;
    localparam int C_STAT_TX_EMPTY = 2;
    localparam int C_STAT_RX_FULL  = 1;
    localparam int C_STAT_RX_EMPTY = 0;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_DATA = 2'd1,
        RD_STAT = 2'd2
    } rd_state_e;

    function automatic logic [7:0] status_byte(
        input logic tx_ovf,
        input logic rx_unf,
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty
    );
        logic [7:0] s;
        s                  = 8'h00;
        s[C_STAT_TX_OVF]   = tx_ovf;
        s[C_STAT_RX_UNF]   = rx_unf;
        s[C_STAT_TX_FULL]  = tx_full;
        s[C_STAT_TX_EMPTY] = tx_empty;
        s[C_STAT_RX_FULL]  = rx_full;
        s[C_STAT_RX_EMPTY] = rx_empty;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wca_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wca_byte_fifo
// Description : Show-ahead synchronous byte FIFO of 2**DEPTH_LOG2 entries.
//               dout_o always presents the head entry. A push while full is
//               accepted only when a pop happens in the same cycle.
// Ports       : clock, reset (async, active-high)
//               push_i/din_i  - write side
//               pop_i         - read side (ignored when empty)
//               dout_o        - head entry
//               full_o/empty_o/level_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module wca_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [7:0]            din_i,
    input  logic                  pop_i,
    output logic [7:0]            dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                w_push;
    logic                w_pop;

    // Pointers carry one extra MSB so full and empty are distinguishable
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign dout_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wca_reg_byte_fifo_port.sv
`default_nettype none
// ============================================================================
// Module      : wca_reg_byte_fifo_port
// Description : Register-bus slave exposing a byte-stream port. Host writes
//               to ADDR_DATA push the TX FIFO; host reads of ADDR_DATA pop
//               the RX FIFO. ADDR_STAT returns FIFO status and sticky error
//               flags (write-1-to-clear).
// Ports       : clock, reset    - bus clock, async active-high reset
//               rbusCtrl        - {addr[7:0], rdActive, wrStart, endStrobe, clkbus}
//               rbusData        - tri-state data, driven only during a decoded read
//               tx_data/tx_valid/tx_ready - TX stream towards internal logic
//               rx_data/rx_valid/rx_ready - RX stream from internal logic
//               tx_level/rx_level         - FIFO occupancies
// Revision    : 1.0 - initial release
// ============================================================================
module wca_reg_byte_fifo_port
    import wca_reg_byte_fifo_port_pkg::*;
#(
    parameter logic [7:0] ADDR_DATA  = 8'h20,
    parameter logic [7:0] ADDR_STAT  = 8'h21,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [11:0]           rbusCtrl,
    inout  wire  [7:0]            rbusData,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic [DEPTH_LOG2:0]   rx_level
);

    logic [7:0] w_addr;
    logic       w_rd_active;
    logic       w_wr_start;
    logic       w_end_strobe;
    logic       w_unused_clkbus;
    logic       w_hit_data;
    logic       w_hit_stat;
    logic       w_stat_wr;

    rd_state_e  state_q;
    logic [7:0] rd_hold_q;
    logic       rd_empty_q;
    logic       tx_ovf_q;
    logic       tx_ovf_d;
    logic       rx_unf_q;
    logic       rx_unf_d;

    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;
    logic [7:0] w_status;
    logic       w_tx_push_req;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_leave;
    logic       w_unf_evt;

    // ---------------- bus decode ----------------
    assign w_addr          = rbusCtrl[C_CTRL_ADDR_MSB:C_CTRL_ADDR_LSB];
    assign w_rd_active     = rbusCtrl[C_CTRL_RD];
    assign w_wr_start      = rbusCtrl[C_CTRL_WR];
    assign w_end_strobe    = rbusCtrl[C_CTRL_STB];
    // Bus bridge runs on this same clock, so the forwarded bus clock is not needed
    assign w_unused_clkbus = rbusCtrl[C_CTRL_CLK];
    assign w_hit_data      = (w_addr == ADDR_DATA);
    assign w_hit_stat      = (w_addr == ADDR_STAT);
    assign w_stat_wr       = w_wr_start && w_hit_stat;

    // ---------------- FIFO control ----------------
    // Host push is judged against the full flag alone: a same-cycle drain
    // never rescues a host write into a full FIFO.
    assign w_tx_push_req = w_wr_start && w_hit_data;
    assign w_tx_push     = w_tx_push_req && !w_tx_full;
    assign tx_valid      = !w_tx_empty;
    assign w_tx_pop      = tx_valid && tx_ready;

    assign w_leave   = (state_q != RD_IDLE) && w_end_strobe;
    assign w_rx_pop  = w_leave && (state_q == RD_DATA) && !rd_empty_q;
    assign w_unf_evt = w_leave && (state_q == RD_DATA) && rd_empty_q;
    // The producer may refill the slot a host pop frees in the same cycle
    assign rx_ready  = !w_rx_full || w_rx_pop;
    assign w_rx_push = rx_valid && rx_ready;

    assign w_status = status_byte(tx_ovf_q, rx_unf_q, w_tx_full, w_tx_empty,
                                  w_rx_full, w_rx_empty);

    wca_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (w_tx_push),
        .din_i   (rbusData),
        .pop_i   (w_tx_pop),
        .dout_o  (tx_data),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty),
        .level_o (tx_level)
    );

    wca_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (w_rx_push),
        .din_i   (rx_data),
        .pop_i   (w_rx_pop),
        .dout_o  (w_rx_head),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty),
        .level_o (rx_level)
    );

    // ---------------- sticky flags ----------------
    // A new error event in the same cycle as its clear leaves the flag set
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (w_stat_wr && rbusData[C_STAT_TX_OVF]) begin
            tx_ovf_d = 1'b0;
        end
        if (w_stat_wr && rbusData[C_STAT_RX_UNF]) begin
            rx_unf_d = 1'b0;
        end
        if (w_tx_push_req && w_tx_full) begin
            tx_ovf_d = 1'b1;
        end
        if (w_unf_evt) begin
            rx_unf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    // ---------------- read FSM ----------------
    // The read value is snapshotted on entry so the host sees a stable byte
    // for the whole access; the RX pop is deferred until endStrobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RD_IDLE;
            rd_hold_q  <= 8'h00;
            rd_empty_q <= 1'b1;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (w_rd_active && w_hit_data) begin
                        state_q    <= RD_DATA;
                        rd_hold_q  <= w_rx_empty ? 8'h00 : w_rx_head;
                        rd_empty_q <= w_rx_empty;
                    end else if (w_rd_active && w_hit_stat) begin
                        state_q    <= RD_STAT;
                        rd_hold_q  <= w_status;
                    end
                end
                default: begin
                    if (w_end_strobe) begin
                        state_q <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Drive only once the FSM has left IDLE, giving a one-cycle turnaround
    assign rbusData = ((state_q != RD_IDLE) && w_rd_active) ? rd_hold_q : 8'hzz;

endmodule
`default_nettype wire
